// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the SRAM controller: FSM state and operation enums,
// default memory map base and wait-state count, and the byte-address to
// SRAM word-index helper.
// No ports (package).
// -----------------------------------------------------------------------------
package arm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LO,
      ST_HI,
      ST_DONE
   } sram_state_e;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } sram_op_e;

   localparam logic [31:0] DEFAULT_MEM_BASE    = 32'd1024;
   localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

   // 32-bit subtract wraps modulo 2^32; only the low 17 word bits reach the SRAM.
   function automatic logic [16:0] word_index(input logic [31:0] addr,
                                              input logic [31:0] base);
      return 17'((addr - base) >> 2);
   endfunction

endpackage

// File: rtl/sram_controller_if.sv
// -----------------------------------------------------------------------------
// sram_controller_if
// Bundles the memory-stage request/response signals and the 16-bit SRAM bus.
//   wrEn/rdEn/address/writeData : memory-stage request (from pipeline)
//   readData/ready              : load data and pipeline freeze/complete
//   sramAddr/sramDqOut/sramDqOe : half-word address, write data, bus drive
//   sramDqIn                    : read data returned by the SRAM
//   sramWeN/OeN/CeN/UbN/LbN     : active-low SRAM strobes
// Modports: slave = controller, master = pipeline/SRAM environment.
// -----------------------------------------------------------------------------
interface sram_controller_if;
   logic        wrEn;
   logic        rdEn;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        ready;
   logic [17:0] sramAddr;
   logic [15:0] sramDqOut;
   logic [15:0] sramDqIn;
   logic        sramDqOe;
   logic        sramWeN;
   logic        sramOeN;
   logic        sramCeN;
   logic        sramUbN;
   logic        sramLbN;

   modport slave (
      input  wrEn, rdEn, address, writeData, sramDqIn,
      output readData, ready, sramAddr, sramDqOut, sramDqOe,
             sramWeN, sramOeN, sramCeN, sramUbN, sramLbN
   );

   modport master (
      output wrEn, rdEn, address, writeData, sramDqIn,
      input  readData, ready, sramAddr, sramDqOut, sramDqOe,
             sramWeN, sramOeN, sramCeN, sramUbN, sramLbN
   );
endinterface

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Splits each 32-bit memory-stage access into two 16-bit SRAM half-accesses
// (low half then high half), each held for WAIT_CYCLES cycles, and freezes
// the pipeline via ready until the access completes.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : sram_controller_if.slave (request, response and SRAM bus)
// Parameters:
//   WAIT_CYCLES : cycles per half-access (1..15)
//   MEM_BASE    : byte address mapped to SRAM word 0
// -----------------------------------------------------------------------------
module sram_controller
   import arm_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
   parameter logic [31:0] MEM_BASE    = DEFAULT_MEM_BASE
) (
   input  logic             clk,
   input  logic             rst,
   sram_controller_if.slave bus
);

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   sram_state_e state_q, state_d;
   sram_op_e    op_q, op_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [16:0] idx_q, idx_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic        req;
   logic        active;
   logic        is_write;
   logic        half_hi;

   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic        sram_we_n;
   logic        sram_oe_n;

   assign req = bus.wrEn | bus.rdEn;

   // Next-state: request is sampled only in IDLE, so a request still held
   // during DONE is not mistaken for a new access.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (req) begin
               state_d = ST_LO;
               op_d    = bus.wrEn ? OP_WRITE : OP_READ;
               idx_d   = word_index(bus.address, MEM_BASE);
               wdata_d = bus.writeData;
            end
         end
         ST_LO: begin
            if (cnt_q == LAST_CNT) begin
               state_d = ST_HI;
               cnt_d   = '0;
               if (op_q == OP_READ) rdata_d[15:0] = bus.sramDqIn;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_HI: begin
            if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               if (op_q == OP_READ) rdata_d[31:16] = bus.sramDqIn;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_READ;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // SRAM side decoded from state and latched request only.
   assign active   = (state_q == ST_LO) || (state_q == ST_HI);
   assign is_write = (op_q == OP_WRITE);
   assign half_hi  = (state_q == ST_HI);

   always_comb begin
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      sram_oe_n   = 1'b1;
      if (active) begin
         sram_addr  = {idx_q, half_hi};
         sram_dq_oe = is_write;
         sram_we_n  = ~is_write;
         sram_oe_n  = is_write;
         if (is_write) sram_dq_out = half_hi ? wdata_q[31:16] : wdata_q[15:0];
      end
   end

   assign bus.sramAddr  = sram_addr;
   assign bus.sramDqOut = sram_dq_out;
   assign bus.sramDqOe  = sram_dq_oe;
   assign bus.sramWeN   = sram_we_n;
   assign bus.sramOeN   = sram_oe_n;
   assign bus.sramCeN   = ~active;
   assign bus.sramUbN   = ~active;
   assign bus.sramLbN   = ~active;
   assign bus.readData  = rdata_q;
   assign bus.ready     = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
// Two controller instances (WAIT_CYCLES=2 and 1) sharing one SRAM array
// model. Each access is checked cycle by cycle against a timeline derived
// from the access rules: one IDLE cycle with ready low, WAIT_CYCLES low-half
// cycles, WAIT_CYCLES high-half cycles, one DONE cycle with ready high.
// -----------------------------------------------------------------------------
module tb_sram_controller;

   typedef struct packed {
      logic        ready;
      logic [17:0] addr;
      logic [15:0] dq;
      logic        oe;
      logic        we_n;
      logic        oe_n;
      logic        ce_n;
      logic        ub_n;
      logic        lb_n;
      logic [31:0] rdata;
   } obs_t;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [17:0] e_lo;
      logic [17:0] e_hi;
      logic [31:0] e_rd;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int          sel       = 0;
   logic        drv_wr    = 1'b0;
   logic        drv_rd    = 1'b0;
   logic [31:0] drv_addr  = '0;
   logic [31:0] drv_wdata = '0;

   logic [15:0] mem [0:262143];
   logic [31:0] exp_rd [0:1];
   int          n_tests = 0;
   int          n_fail  = 0;

   sram_controller_if if0 ();
   sram_controller_if if1 ();

   sram_controller #(.WAIT_CYCLES(2), .MEM_BASE(32'd1024)) dut0 (
      .clk(clk), .rst(rst), .bus(if0.slave));
   sram_controller #(.WAIT_CYCLES(1), .MEM_BASE(32'd1024)) dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave));

   assign if0.wrEn      = (sel == 0) && drv_wr;
   assign if0.rdEn      = (sel == 0) && drv_rd;
   assign if0.address   = (sel == 0) ? drv_addr : '0;
   assign if0.writeData = (sel == 0) ? drv_wdata : '0;
   assign if0.sramDqIn  = mem[if0.sramAddr];

   assign if1.wrEn      = (sel == 1) && drv_wr;
   assign if1.rdEn      = (sel == 1) && drv_rd;
   assign if1.address   = (sel == 1) ? drv_addr : '0;
   assign if1.writeData = (sel == 1) ? drv_wdata : '0;
   assign if1.sramDqIn  = mem[if1.sramAddr];

   obs_t o0, o1;
   assign o0 = {if0.ready, if0.sramAddr, if0.sramDqOut, if0.sramDqOe, if0.sramWeN,
                if0.sramOeN, if0.sramCeN, if0.sramUbN, if0.sramLbN, if0.readData};
   assign o1 = {if1.ready, if1.sramAddr, if1.sramDqOut, if1.sramDqOe, if1.sramWeN,
                if1.sramOeN, if1.sramCeN, if1.sramUbN, if1.sramLbN, if1.readData};

   function automatic obs_t idle_obs(input logic [31:0] rd);
      obs_t o;
      o.ready = 1'b1; o.addr = '0; o.dq = '0; o.oe = 1'b0;
      o.we_n = 1'b1; o.oe_n = 1'b1; o.ce_n = 1'b1; o.ub_n = 1'b1; o.lb_n = 1'b1;
      o.rdata = rd;
      return o;
   endfunction

   // Word index from plain arithmetic: bytes above the base, four per word.
   function automatic logic [16:0] model_idx(input logic [31:0] addr);
      logic [31:0] words;
      words = (addr - 32'd1024) / 32'd4;
      return words[16:0];
   endfunction

   task automatic check(input string name, input int s, input obs_t e, input obs_t m);
      obs_t a;
      a = (s == 0) ? o0 : o1;
      n_tests++;
      if (((a ^ e) & m) != '0) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (mask %h)", name, a, e, m);
      end
   endtask

   task automatic run_txn(input string name, input int s, input logic wr, input logic rd,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [17:0] e_lo, input logic [17:0] e_hi,
                          input logic [31:0] e_rd, input int drop_c, input bit b2b);
      int          w, last, stop;
      bit          hi;
      obs_t        e, m;
      logic [31:0] prev;
      w    = (s == 0) ? 2 : 1;
      last = 2 * w + 1;
      stop = b2b ? last : last + 1;
      prev = exp_rd[s];
      for (int c = 0; c <= stop; c++) begin
         @(negedge clk);
         sel = s;
         if (c < drop_c && c <= last) begin
            drv_wr = wr; drv_rd = rd; drv_addr = addr; drv_wdata = wdata;
         end else if (c <= last) begin
            drv_wr = 1'b0; drv_rd = 1'b0; drv_addr = $urandom; drv_wdata = $urandom;
         end else begin
            drv_wr = 1'b0; drv_rd = 1'b0; drv_addr = '0; drv_wdata = '0;
         end
         #1;
         e = idle_obs(prev);
         m = '1; m.addr = '0; m.dq = '0;
         if (c == 0) begin
            e.ready = 1'b0;
         end else if (c < last) begin
            hi = (c > w);
            e.ready = 1'b0; e.ce_n = 1'b0; e.ub_n = 1'b0; e.lb_n = 1'b0;
            e.we_n = !wr; e.oe_n = wr; e.oe = wr;
            e.addr = hi ? e_hi : e_lo; m.addr = '1;
            if (wr) begin
               e.dq = hi ? wdata[31:16] : wdata[15:0];
               m.dq = '1;
            end
            if (hi && !wr) e.rdata = {prev[31:16], e_rd[15:0]};
         end else begin
            e.rdata = e_rd;
         end
         check($sformatf("%s c%0d", name, c), s, e, m);
      end
      exp_rd[s] = e_rd;
   endtask

   vec_t vecs [6];

   initial begin
      obs_t        e, m;
      logic        wr, rd;
      logic [31:0] addr, wdata, e_rd;
      logic [16:0] idx;
      int          s, drop;
      bit          b2b;

      exp_rd[0] = '0;
      exp_rd[1] = '0;
      for (int i = 0; i < 262144; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h1111;       mem[1] = 16'h2222;
      mem[2] = 16'h1234;       mem[3] = 16'hABCD;
      mem[18'h3FFFE] = 16'h5555; mem[18'h3FFFF] = 16'hAAAA;

      vecs[0] = '{1'b1, 1'b0, 32'd1024,    32'hDEADBEEF, 18'd0,       18'd1,       32'h00000000};
      vecs[1] = '{1'b0, 1'b1, 32'd1028,    32'h00000000, 18'd2,       18'd3,       32'hABCD1234};
      vecs[2] = '{1'b1, 1'b1, 32'd1032,    32'h0BADF00D, 18'd4,       18'd5,       32'hABCD1234};
      vecs[3] = '{1'b0, 1'b1, 32'd1020,    32'h00000000, 18'h3FFFE,   18'h3FFFF,   32'hAAAA5555};
      vecs[4] = '{1'b1, 1'b0, 32'd1023,    32'h600DCAFE, 18'h3FFFE,   18'h3FFFF,   32'hAAAA5555};
      vecs[5] = '{1'b0, 1'b1, 32'h00080400, 32'h00000000, 18'd0,      18'd1,       32'h22221111};

      // Reset state of both instances.
      repeat (2) @(negedge clk);
      #1;
      check("reset_w2", 0, idle_obs(32'h0), '1);
      check("reset_w1", 1, idle_obs(32'h0), '1);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i])
         run_txn($sformatf("vec%0d", i), 0, vecs[i].wr, vecs[i].rd, vecs[i].addr,
                 vecs[i].wdata, vecs[i].e_lo, vecs[i].e_hi, vecs[i].e_rd, 99, 1'b0);

      // Randomized accesses against the timeline model.
      for (int k = 0; k < 30; k++) begin
         s     = $urandom_range(0, 1);
         wr    = 1'($urandom_range(0, 1));
         rd    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         addr  = $urandom;
         wdata = $urandom;
         idx   = model_idx(addr);
         e_rd  = wr ? exp_rd[s] : {mem[{idx, 1'b1}], mem[{idx, 1'b0}]};
         drop  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 99;
         b2b   = (k != 29) && ($urandom_range(0, 1) == 1);
         run_txn($sformatf("rnd%0d", k), s, wr, rd, addr, wdata,
                 {idx, 1'b0}, {idx, 1'b1}, e_rd, drop, b2b);
      end

      // Read held through DONE, still high in the following IDLE: exactly two accesses.
      run_txn("hold_a", 0, 1'b0, 1'b1, 32'd1020, '0, 18'h3FFFE, 18'h3FFFF, 32'hAAAA5555, 99, 1'b1);
      run_txn("hold_b", 0, 1'b0, 1'b1, 32'd1028, '0, 18'd2, 18'd3, 32'hABCD1234, 99, 1'b0);

      // Requests withdrawn mid-access; address/data scrambled afterwards.
      run_txn("drop_wr", 0, 1'b1, 1'b0, 32'd1040, 32'h89ABCDEF, 18'd8, 18'd9, exp_rd[0], 2, 1'b0);
      run_txn("drop_rd", 0, 1'b0, 1'b1, 32'h00080400, '0, 18'd0, 18'd1, 32'h22221111, 1, 1'b0);

      // Reset asserted in the high half of a write.
      @(negedge clk);
      sel = 0; drv_wr = 1'b1; drv_rd = 1'b0; drv_addr = 32'd1032; drv_wdata = 32'hCAFEF00D;
      repeat (3) @(negedge clk);
      #1;
      e = idle_obs(32'h0); m = '0;
      e.addr = 18'd5; e.we_n = 1'b0; m.addr = '1; m.we_n = 1'b1;
      check("rst_in_hi", 0, e, m);
      drv_wr = 1'b0; drv_addr = '0; drv_wdata = '0;
      rst = 1'b0;
      #1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      check("rst_abort_w2", 0, idle_obs(32'h0), '1);
      check("rst_abort_w1", 1, idle_obs(32'h0), '1);
      @(negedge clk);
      #1;
      check("rst_held", 0, idle_obs(32'h0), '1);
      rst = 1'b1;
      run_txn("after_rst", 0, 1'b0, 1'b1, 32'd1028, '0, 18'd2, 18'd3, 32'hABCD1234, 99, 1'b0);

      // Single wait cycle: back-to-back writes, wrapping address, then a read.
      run_txn("w1_wrap", 1, 1'b1, 1'b0, 32'd1020, 32'h13572468, 18'h3FFFE, 18'h3FFFF, exp_rd[1], 99, 1'b1);
      run_txn("w1_b2b", 1, 1'b1, 1'b0, 32'd1036, 32'h0F1E2D3C, 18'd6, 18'd7, exp_rd[1], 99, 1'b0);
      run_txn("w1_rd", 1, 1'b0, 1'b1, 32'd1020, '0, 18'h3FFFE, 18'h3FFFF, 32'hAAAA5555, 99, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
